// File: rtl/uart_rx_buffered_pkg.sv
// uart_rx_buffered_pkg: receiver FSM states and UART defaults shared with the transmitter
package uart_rx_buffered_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_DIV_W = 4;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word-fall-through FIFO; a pop frees room for a same-cycle push when full
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_wr, do_rd;
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || rd_en);
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign rd_data = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_rd ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end
endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 receiver with start-glitch filter, framing check and receive FIFO
module uart_rx_buffered
  import uart_rx_buffered_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int DEPTH = 8,
  parameter int DIV_W = UART_DIV_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIV_W-1:0]       clk_div,
  input  logic                   rx_serial,
  input  logic                   rd_en,
  output logic [DATA_BITS-1:0]   rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   rx_active,
  output logic                   frame_err,
  output logic                   overrun
);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
  rx_state_t state;
  logic [1:0] sync;
  logic rx_s;
  logic [DIV_W-1:0] cnt, d_lat, d_eff, h;
  logic [BW-1:0] bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic bit_end, wr_en;
  assign rx_s = sync[1];
  assign d_eff = clk_div < DIV_W'(2) ? DIV_W'(2) : clk_div;
  assign h = d_lat >> 1;
  assign bit_end = cnt == d_lat - 1'b1;
  // push straight from the stop sample so the byte is visible the very next cycle
  assign wr_en = state == STOP && bit_end && rx_s;
  assign rx_active = state == START || state == DATA || state == STOP;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      d_lat <= '0;
      bit_idx <= '0;
      shreg <= '0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sync <= {sync[0], rx_serial};
      frame_err <= 1'b0;
      overrun <= wr_en && full && !rd_en;
      case (state)
        IDLE: begin
          cnt <= '0;
          d_lat <= d_eff;
          state <= rx_s ? IDLE : START;
        end
        START: begin
          cnt <= cnt == h - 1'b1 ? '0 : cnt + 1'b1;
          bit_idx <= '0;
          state <= cnt != h - 1'b1 ? START : rx_s ? IDLE : DATA;
        end
        DATA: begin
          cnt <= bit_end ? '0 : cnt + 1'b1;
          if (bit_end) begin
            shreg[bit_idx] <= rx_s;
            bit_idx <= bit_idx + 1'b1;
            state <= bit_idx == LAST ? STOP : DATA;
          end
        end
        STOP: begin
          cnt <= bit_end ? '0 : cnt + 1'b1;
          frame_err <= bit_end && !rx_s;
          state <= !bit_end ? STOP : rx_s ? IDLE : WAIT_IDLE;
        end
        WAIT_IDLE: state <= rx_s ? IDLE : WAIT_IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(shreg),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: vector table plus corner-case sequences, scoreboard queue of expected bytes
module tb_uart_rx_buffered;
  logic clk = 0, rst = 1;
  logic [3:0] clk_div = 4'd2;
  logic rx_serial = 1, rd_en = 0;
  logic [7:0] rd_data;
  logic empty, full, rx_active, frame_err, overrun;
  logic [3:0] count;
  int applied = 0, miss = 0, fe_cnt = 0, ov_cnt = 0, act_cnt = 0;
  logic [7:0] q[$];
  typedef struct {
    logic [3:0] div;
    logic [7:0] data;
    logic stop;
    logic push;
  } vec_t;

  always #5 clk = ~clk;

  uart_rx_buffered dut (
    .clk(clk), .rst(rst), .clk_div(clk_div), .rx_serial(rx_serial), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .rx_active(rx_active), .frame_err(frame_err), .overrun(overrun)
  );

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (rx_active) act_cnt++;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int d, input logic stop, input int hold);
    rx_serial = 0;
    repeat (d) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (d) @(negedge clk);
    end
    rx_serial = stop;
    repeat (d + hold) @(negedge clk);
    rx_serial = 1;
  endtask

  task automatic pop;
    chk("pop_not_empty", empty, 0);
    applied++;
    if (q.size() == 0) begin
      miss++;
      $display("FAIL pop_data: got 0x%0h with no byte expected", rd_data);
    end else if (rd_data !== q[0]) begin
      miss++;
      $display("FAIL pop_data: got 0x%0h expected 0x%0h", rd_data, q[0]);
    end
    if (q.size() != 0) void'(q.pop_front());
    rd_en = 1;
    @(negedge clk);
    rd_en = 0;
  endtask

  task automatic chk_reset;
    chk("rst_rd_data", rd_data, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_rx_active", rx_active, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
  endtask

  // edge count from driving the start bit to the stop-sample edge
  function automatic int stop_edge(input int div);
    int d;
    d = div < 2 ? 2 : div;
    return 3 + d / 2 + 9 * d;
  endfunction

  initial begin
    vec_t v[6];
    int s, d, fe0, ov0, a0;
    v = '{'{4'd2, 8'hA5, 1'b1, 1'b1}, '{4'd0, 8'h3C, 1'b1, 1'b1}, '{4'd1, 8'hC3, 1'b1, 1'b1},
          '{4'd3, 8'h81, 1'b1, 1'b1}, '{4'd15, 8'h7E, 1'b1, 1'b1}, '{4'd4, 8'h55, 1'b0, 1'b0}};
    idle(3);
    chk_reset();
    rst = 0;
    idle(3);

    for (int i = 0; i < 6; i++) begin
      clk_div = v[i].div;
      d = v[i].div < 2 ? 2 : int'(v[i].div);
      s = stop_edge(d);
      fe0 = fe_cnt;
      if (v[i].push) q.push_back(v[i].data);
      fork
        send(v[i].data, d, v[i].stop, 0);
        begin
          repeat (s - 1) @(negedge clk);
          chk("empty_before_stop", empty, 1);
          @(negedge clk);
          chk("empty_after_stop", empty, !v[i].push);
          chk("frame_err_at_stop", frame_err, !v[i].stop);
          chk("count_after_stop", count, 32'(v[i].push));
        end
      join
      idle(4);
      chk("frame_err_pulses", fe_cnt - fe0, !v[i].stop);
      if (v[i].push) pop();
      chk("count_after_pop", count, 0);
    end

    clk_div = 4'd8;
    a0 = act_cnt;
    fe0 = fe_cnt;
    rx_serial = 0;
    idle(2);
    rx_serial = 1;
    idle(20);
    chk("glitch_active_cycles", act_cnt - a0, 4);
    chk("glitch_frame_err", fe_cnt - fe0, 0);
    chk("glitch_count", count, 0);
    chk("glitch_idle", rx_active, 0);

    clk_div = 4'd4;
    fe0 = fe_cnt;
    send(8'h3C, 4, 0, 20);
    idle(5);
    chk("break_frame_err", fe_cnt - fe0, 1);
    chk("break_count", count, 0);
    q.push_back(8'h5A);
    send(8'h5A, 4, 1, 0);
    idle(6);
    pop();

    for (int k = 0; k < 8; k++) begin
      q.push_back(8'(k));
      send(8'(k), 4, 1, 0);
    end
    idle(6);
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    ov0 = ov_cnt;
    send(8'hFF, 4, 1, 0);
    idle(6);
    chk("overrun_pulses", ov_cnt - ov0, 1);
    chk("overrun_count", count, 8);

    ov0 = ov_cnt;
    s = stop_edge(4);
    fork
      send(8'h11, 4, 1, 0);
      begin
        repeat (s - 1) @(negedge clk);
        chk("same_cycle_head", rd_data, q[0]);
        void'(q.pop_front());
        rd_en = 1;
        @(negedge clk);
        rd_en = 0;
        chk("same_cycle_overrun", overrun, 0);
        chk("same_cycle_count", count, 8);
      end
    join
    q.push_back(8'h11);
    idle(4);
    chk("same_cycle_no_overrun", ov_cnt - ov0, 0);
    for (int k = 0; k < 8; k++) pop();
    chk("drained_empty", empty, 1);

    q.push_back(8'h42);
    send(8'h42, 4, 1, 0);
    idle(6);
    chk("pre_reset_count", count, 1);
    fork
      send(8'h96, 4, 1, 0);
      begin
        idle(15);
        rst = 1;
        @(negedge clk);
        chk_reset();
      end
    join
    idle(2);
    chk_reset();
    rst = 0;
    q.delete();
    idle(5);
    chk("post_reset_empty", empty, 1);
    q.push_back(8'h69);
    send(8'h69, 4, 1, 0);
    idle(6);
    chk("post_reset_count", count, 1);
    pop();
    chk("post_reset_drained", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miss);
    $finish;
  end
endmodule
